// File: rtl/vx_gpr_banked.sv
`default_nettype none
// ============================================================================
// Module   : vx_gpr_banked
// Brief    : Banked per-core GPR file with multi-round operand collection.
//            Optional macro GPR_WB_BYPASS_EN selects write-first bank reads.
// Revision : 1.0
// ============================================================================
module vx_gpr_banked #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 32,
    parameter int NUM_BANKS   = 2,
    parameter int NUM_RPORTS  = 3,
    parameter int DATAW       = 32,
    parameter int TAGW        = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic [$clog2(NUM_WARPS)-1:0]            req_wid,
    input  logic [NUM_RPORTS*$clog2(NUM_REGS)-1:0]  req_rs,
    input  logic [NUM_RPORTS-1:0]                   req_rs_mask,
    input  logic [TAGW-1:0]                         req_tag,
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [TAGW-1:0]                         rsp_tag,
    output logic [NUM_RPORTS*NUM_THREADS*DATAW-1:0] rsp_data,
    input  logic                                    wb_valid,
    output logic                                    wb_ready,
    input  logic [$clog2(NUM_WARPS)-1:0]            wb_wid,
    input  logic [$clog2(NUM_REGS)-1:0]             wb_rd,
    input  logic [NUM_THREADS-1:0]                  wb_tmask,
    input  logic [NUM_THREADS*DATAW-1:0]            wb_data
);

    localparam int WIDW  = $clog2(NUM_WARPS);
    localparam int RSW   = $clog2(NUM_REGS);
    localparam int LOG2B = $clog2(NUM_BANKS);
    localparam int BSELW = (NUM_BANKS > 1) ? LOG2B : 1;
    localparam int DEPTH = NUM_WARPS * NUM_REGS / NUM_BANKS;
    localparam int ADDRW = WIDW + RSW - LOG2B;
    localparam int LINEW = NUM_THREADS * DATAW;
    localparam int PIDXW = (NUM_RPORTS > 1) ? $clog2(NUM_RPORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_RSP     = 2'd3
    } state_t;

    // Consecutive registers of a warp land in different banks; the warp id skews the start bank.
    function automatic logic [BSELW-1:0] bank_of(input logic [WIDW-1:0] wid, input logic [RSW-1:0] rs);
        logic [RSW-1:0] sum;
        sum = rs + RSW'(wid);
        if (NUM_BANKS == 1) return '0;
        return sum[BSELW-1:0];
    endfunction

    function automatic logic [ADDRW-1:0] addr_of(input logic [WIDW-1:0] wid, input logic [RSW-1:0] rs);
        logic [WIDW+RSW-1:0] cat;
        cat = {wid, rs};
        return ADDRW'(cat >> LOG2B);
    endfunction

    state_t                                state_q, state_d;
    logic                                  req_ready_q, req_ready_d;
    logic                                  rsp_valid_q, rsp_valid_d;
    logic [TAGW-1:0]                       rsp_tag_q, rsp_tag_d;
    logic [NUM_RPORTS*LINEW-1:0]           rsp_data_q, rsp_data_d;
    logic [WIDW-1:0]                       wid_q, wid_d;
    logic [NUM_RPORTS-1:0][RSW-1:0]        rs_q, rs_d;
    logic [TAGW-1:0]                       tag_q, tag_d;
    logic [NUM_RPORTS-1:0]                 pending_q, pending_d;
    logic [NUM_RPORTS-1:0]                 latch_q, latch_d;
    logic [NUM_RPORTS-1:0][LINEW-1:0]      opnd_q, opnd_d;

    logic [NUM_RPORTS-1:0][BSELW-1:0]      port_bank;
    logic [NUM_RPORTS-1:0][ADDRW-1:0]      port_addr;
    logic [NUM_RPORTS-1:0]                 served;
    logic [NUM_BANKS-1:0]                  rd_en;
    logic [NUM_BANKS-1:0][ADDRW-1:0]       rd_addr;
    logic [NUM_BANKS-1:0][LINEW-1:0]       bank_rdata;
    logic [BSELW-1:0]                      wb_bank;
    logic [ADDRW-1:0]                      wb_addr;

    assign wb_ready  = 1'b1;
    assign wb_bank   = bank_of(wb_wid, wb_rd);
    assign wb_addr   = addr_of(wb_wid, wb_rd);
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            port_bank[p] = bank_of(wid_q, rs_q[p]);
            port_addr[p] = addr_of(wid_q, rs_q[p]);
        end
    end

    // Per bank: grant the lowest pending port; same-register ports ride on that read.
    always_comb begin : p_grant
        logic             found;
        logic [PIDXW-1:0] gidx;
        found   = 1'b0;
        gidx    = '0;
        served  = '0;
        rd_en   = '0;
        rd_addr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            found = 1'b0;
            gidx  = '0;
            for (int p = 0; p < NUM_RPORTS; p++) begin
                if (!found && pending_q[p] && port_bank[p] == BSELW'(b)) begin
                    found = 1'b1;
                    gidx  = PIDXW'(p);
                end
            end
            rd_en[b]   = found && (state_q == S_COLLECT);
            rd_addr[b] = port_addr[gidx];
            for (int p = 0; p < NUM_RPORTS; p++) begin
                if (rd_en[b] && pending_q[p] && rs_q[p] == rs_q[gidx]) served[p] = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [LINEW-1:0] mem [DEPTH];
        logic [LINEW-1:0] rdata_d, rdata_q;
        logic             wr_en;

        assign wr_en = wb_valid && (wb_rd != '0) && (wb_bank == BSELW'(b));

        always_comb begin
            rdata_d = mem[rd_addr[b]];
`ifdef GPR_WB_BYPASS_EN
            if (wr_en && wb_addr == rd_addr[b]) begin
                for (int l = 0; l < NUM_THREADS; l++) begin
                    if (wb_tmask[l]) rdata_d[l*DATAW +: DATAW] = wb_data[l*DATAW +: DATAW];
                end
            end
`endif
        end

        always_ff @(posedge clk) begin
            if (wr_en) begin
                for (int l = 0; l < NUM_THREADS; l++) begin
                    if (wb_tmask[l]) mem[wb_addr][l*DATAW +: DATAW] <= wb_data[l*DATAW +: DATAW];
                end
            end
            if (rd_en[b]) rdata_q <= rdata_d;
        end

        assign bank_rdata[b] = rdata_q;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_data_d  = rsp_data_q;
        wid_d       = wid_q;
        rs_d        = rs_q;
        tag_d       = tag_q;
        pending_d   = pending_q;
        latch_d     = '0;
        opnd_d      = opnd_q;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            if (latch_q[p]) opnd_d[p] = bank_rdata[port_bank[p]];
        end
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    wid_d       = req_wid;
                    rs_d        = req_rs;
                    tag_d       = req_tag;
                    req_ready_d = 1'b0;
                    for (int p = 0; p < NUM_RPORTS; p++) begin
                        pending_d[p] = req_rs_mask[p] && (req_rs[p*RSW +: RSW] != '0);
                        opnd_d[p]    = '0;
                    end
                    state_d = (pending_d != '0) ? S_COLLECT : S_RSP;
                end
            end
            S_COLLECT: begin
                pending_d = pending_q & ~served;
                latch_d   = served;
                if (pending_d == '0) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_RSP;
            S_RSP: begin
                // First RSP cycle snapshots the collected operands into the output register.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_tag_d   = tag_q;
                    rsp_data_d  = opnd_q;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            wid_q       <= '0;
            rs_q        <= '0;
            tag_q       <= '0;
            pending_q   <= '0;
            latch_q     <= '0;
            opnd_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
            wid_q       <= wid_d;
            rs_q        <= rs_d;
            tag_q       <= tag_d;
            pending_q   <= pending_d;
            latch_q     <= latch_d;
            opnd_q      <= opnd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_gpr_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_gpr_banked
// Brief    : Directed plus randomized bench for vx_gpr_banked against an
//            array-based register model (honours GPR_WB_BYPASS_EN).
// Revision : 1.0
// ============================================================================
module tb_vx_gpr_banked;

    localparam int NT = 4;
    localparam int NW = 4;
    localparam int NR = 32;
    localparam int NB = 2;
    localparam int NP = 3;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int RW = NP * NT * DW;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_wid;
    logic [14:0]      req_rs;
    logic [NP-1:0]    req_rs_mask;
    logic [TW-1:0]    req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [TW-1:0]    rsp_tag;
    logic [RW-1:0]    rsp_data;
    logic             wb_valid;
    logic             wb_ready;
    logic [1:0]       wb_wid;
    logic [4:0]       wb_rd;
    logic [NT-1:0]    wb_tmask;
    logic [NT*DW-1:0] wb_data;

    vx_gpr_banked dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
        .req_rs(req_rs), .req_rs_mask(req_rs_mask), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid), .wb_rd(wb_rd),
        .wb_tmask(wb_tmask), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] gpr [NW][NR][NT];
    logic [RW-1:0] exp_data;
    logic [TW-1:0] exp_tag;
    int            exp_lat;
    int            total = 0;
    int            bad = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int wid, input int rd, input logic [NT-1:0] tmask, input logic [NT*DW-1:0] data);
        @(negedge clk);
        wb_valid = 1'b1; wb_wid = 2'(wid); wb_rd = 5'(rd); wb_tmask = tmask; wb_data = data;
        @(negedge clk);
        wb_valid = 1'b0;
        if (rd != 0)
            for (int l = 0; l < NT; l++)
                if (tmask[l]) gpr[wid][rd][l] = data[l*DW +: DW];
    endtask

    // Expected response: data snapshot plus latency from distinct registers per bank.
    task automatic start_req(input int wid, input int r0, input int r1, input int r2,
                             input logic [NP-1:0] mask, input logic [TW-1:0] tag);
        int rs [NP];
        int cnt [NB];
        int rounds;
        bit dup;
        rs[0] = r0; rs[1] = r1; rs[2] = r2;
        cnt = '{default: 0};
        @(negedge clk);
        req_valid = 1'b1; req_wid = 2'(wid); req_rs = {5'(r2), 5'(r1), 5'(r0)};
        req_rs_mask = mask; req_tag = tag;
        check("req_ready_idle", RW'(req_ready), RW'(1));
        exp_tag  = tag;
        exp_data = '0;
        for (int p = 0; p < NP; p++) begin
            if (mask[p] && rs[p] != 0) begin
                for (int l = 0; l < NT; l++) exp_data[(p*NT+l)*DW +: DW] = gpr[wid][rs[p]][l];
                dup = 1'b0;
                for (int q = 0; q < p; q++) if (mask[q] && rs[q] == rs[p]) dup = 1'b1;
                if (!dup) cnt[(rs[p] + wid) % NB]++;
            end
        end
        rounds = 0;
        for (int b = 0; b < NB; b++) if (cnt[b] > rounds) rounds = cnt[b];
        exp_lat = (rounds == 0) ? 1 : rounds + 2;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic finish_req(input int start, input int hold, input string name);
        int n;
        n = start;
        while (rsp_valid !== 1'b1 && n < 60) begin
            check({name, "_req_ready_busy"}, RW'(req_ready), RW'(0));
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, RW'(n), RW'(exp_lat));
        check({name, "_data"}, rsp_data, exp_data);
        check({name, "_tag"}, RW'(rsp_tag), RW'(exp_tag));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, RW'(rsp_valid), RW'(1));
            check({name, "_hold_data"}, rsp_data, exp_data);
            check({name, "_hold_req_ready"}, RW'(req_ready), RW'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_valid_drop"}, RW'(rsp_valid), RW'(0));
        check({name, "_req_ready_back"}, RW'(req_ready), RW'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wid = '0; req_rs = '0; req_rs_mask = '0; req_tag = '0;
        rsp_ready = 1'b0; wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_tmask = '0; wb_data = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", RW'(req_ready), RW'(1));
        check("rst_rsp_valid", RW'(rsp_valid), RW'(0));
        check("rst_rsp_tag", RW'(rsp_tag), RW'(0));
        check("rst_rsp_data", rsp_data, '0);
        check("wb_ready", RW'(wb_ready), RW'(1));
        reset = 1'b0;

        for (int w = 0; w < NW; w++) begin
            for (int r = 0; r < NR; r++) for (int l = 0; l < NT; l++) gpr[w][r][l] = '0;
            for (int r = 1; r < NR; r++)
                do_write(w, r, 4'hF, {$urandom, $urandom, $urandom, $urandom});
        end

        do_write(1, 5, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11});
        start_req(1, 5, 6, 0, 3'b111, 8'h01);
        finish_req(0, 0, "w1r5");

        start_req(0, 2, 4, 6, 3'b111, 8'h02);
        finish_req(0, 0, "three_rounds");

        start_req(0, 7, 7, 7, 3'b111, 8'h03);
        finish_req(0, 0, "same_reg");

        do_write(0, 0, 4'hF, {4{32'hDEAD}});
        start_req(0, 0, 3, 3, 3'b001, 8'h04);
        finish_req(0, 0, "r0_only");

        do_write(0, 3, 4'hF, {4{32'hA}});
        start_req(0, 3, 0, 0, 3'b001, 8'h05);
        wb_valid = 1'b1; wb_wid = 2'd0; wb_rd = 5'd3; wb_tmask = 4'b0101; wb_data = {4{32'hB}};
`ifdef GPR_WB_BYPASS_EN
        exp_data[0*DW +: DW] = 32'hB;
        exp_data[2*DW +: DW] = 32'hB;
`endif
        gpr[0][3][0] = 32'hB;
        gpr[0][3][2] = 32'hB;
        @(negedge clk);
        wb_valid = 1'b0;
        finish_req(1, 0, "rdw");

        start_req(2, 1, 2, 3, 3'b111, 8'h06);
        finish_req(0, 10, "hold");

        start_req(0, 2, 4, 6, 3'b111, 8'h07);
        #2 reset = 1'b1;
        #1;
        check("midrst_rsp_valid", RW'(rsp_valid), RW'(0));
        check("midrst_req_ready", RW'(req_ready), RW'(1));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", RW'(rsp_valid), RW'(0));
        end

        for (int it = 0; it < 24; it++) begin
            int w;
            int r [NP];
            repeat ($urandom_range(0, 2))
                do_write($urandom_range(0, NW-1), $urandom_range(0, NR-1), 4'($urandom),
                         {$urandom, $urandom, $urandom, $urandom});
            w = $urandom_range(0, NW-1);
            for (int p = 0; p < NP; p++) r[p] = $urandom_range(0, NR-1);
            if ($urandom_range(0, 2) == 0) r[2] = r[0];
            start_req(w, r[0], r[1], r[2], 3'($urandom), 8'($urandom));
            finish_req(0, $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
